// File: rtl/bullet_line_rasterizer_pkg.sv
// rtl/bullet_line_rasterizer_pkg.sv - shared constants and types for the bullet line rasterizer
//
// Purpose: bullet table field offsets, bullet geometry, video geometry and
//          the scan FSM state encoding shared by the top and the span bank.
// Ports:   none (package).
package bullet_line_rasterizer_pkg;

  // Bullet table word layout
  localparam int X_MSB      = 31;
  localparam int X_LSB      = 22;
  localparam int Y_MSB      = 21;
  localparam int Y_LSB      = 13;
  localparam int ACTIVE_BIT = 3;
  localparam int OWNER_BIT  = 2;

  // Geometry
  localparam int BULLET_SIZE  = 12;
  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bullet_line_rasterizer_span_bank.sv
// rtl/bullet_line_rasterizer_span_bank.sv - span register file with parallel horizontal compare
//
// Purpose: holds up to MAX_SPANS {x, owner} spans for one scanline. Appends
//          in order, clears in one cycle, and compares every valid span
//          against the current pixel x in parallel.
// Ports:
//   clk, reset    clock and synchronous active-high reset (clears count)
//   i_clear       empty the bank (wins over a same-cycle append)
//   i_append      store {i_x, i_owner} at index count; ignored when full
//   i_x, i_owner  span left edge and owner bit
//   i_pix_x       current pixel x for the compare
//   o_full        bank holds MAX_SPANS spans
//   o_hit_vec     per-span hit (only spans below count can hit)
//   o_owner_vec   per-span owner bit
module bullet_line_rasterizer_span_bank #(
  parameter int MAX_SPANS   = 8,
  parameter int BULLET_SIZE = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_append,
  input  logic [9:0]           i_x,
  input  logic                 i_owner,
  input  logic [9:0]           i_pix_x,
  output logic                 o_full,
  output logic [MAX_SPANS-1:0] o_hit_vec,
  output logic [MAX_SPANS-1:0] o_owner_vec
);

  localparam int CW = $clog2(MAX_SPANS + 1);

  logic [CW-1:0]        r_count;
  logic [9:0]           r_x [MAX_SPANS];
  logic [MAX_SPANS-1:0] r_owner;

  assign o_full      = (r_count == CW'(MAX_SPANS));
  assign o_owner_vec = r_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_append && !o_full) begin
      for (int i = 0; i < MAX_SPANS; i++) begin
        if (r_count == CW'(i)) begin
          r_x[i]     <= i_x;
          r_owner[i] <= i_owner;
        end
      end
      r_count <= r_count + CW'(1);
    end
  end

  // 11-bit compare so a span near the right edge never wraps to x=0
  always_comb begin
    o_hit_vec = '0;
    for (int i = 0; i < MAX_SPANS; i++) begin
      o_hit_vec[i] = (CW'(i) < r_count) &&
                     ({1'b0, i_pix_x} >= {1'b0, r_x[i]}) &&
                     ({1'b0, i_pix_x} <  ({1'b0, r_x[i]} + 11'(BULLET_SIZE)));
    end
  end

endmodule

// File: rtl/bullet_line_rasterizer.sv
// rtl/bullet_line_rasterizer.sv - per-scanline bullet span collector and pixel hit generator
//
// Purpose: during horizontal blanking, scans the bullet table once and
//          collects bullets touching the next line into a back span bank;
//          banks swap when the scan drains. During active video, compares
//          pixel x against the front bank only and outputs a registered
//          hit and owner colour.
// Ports:
//   clk, reset       pixel clock, synchronous active-high reset
//   lineEnd, lineY   end-of-line pulse and the y of the line just ended
//   active, pixX     active-video flag and current pixel x
//   bulletRdEn       bullet table read strobe
//   bulletAddr       bullet table index
//   bulletData       table word, valid one cycle after a read strobe
//   pixelHit         registered hit for the previous cycle's pixel
//   pixelColor       registered colour, 0 without a hit
//   scanBusy         scan or drain in progress
//   overflowSticky   some line had more than MAX_SPANS bullets
//   restartSticky    lineEnd arrived while a scan was running
//   statusClear      clears both sticky flags
module bullet_line_rasterizer #(
  parameter int          MAX_BULLETS  = 64,
  parameter int          MAX_SPANS    = 8,
  parameter int          BULLET_SIZE  = bullet_line_rasterizer_pkg::BULLET_SIZE,
  parameter int          VIDEO_HEIGHT = bullet_line_rasterizer_pkg::VIDEO_HEIGHT,
  parameter logic [11:0] COLOR_P1     = 12'hF00,
  parameter logic [11:0] COLOR_P2     = 12'h00F
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           lineEnd,
  input  logic [8:0]                     lineY,
  input  logic                           active,
  input  logic [9:0]                     pixX,
  output logic                           bulletRdEn,
  output logic [$clog2(MAX_BULLETS)-1:0] bulletAddr,
  input  logic [31:0]                    bulletData,
  output logic                           pixelHit,
  output logic [11:0]                    pixelColor,
  output logic                           scanBusy,
  output logic                           overflowSticky,
  output logic                           restartSticky,
  input  logic                           statusClear
);

  import bullet_line_rasterizer_pkg::*;

  localparam int AW = $clog2(MAX_BULLETS);

  scan_state_t r_state;
  logic [8:0]    r_tgt;
  logic [AW-1:0] r_addr;
  logic          r_rd_en;
  logic          r_data_valid;
  logic          r_front;
  logic          r_busy;
  logic          r_hit;
  logic [11:0]   r_color;
  logic          r_ovf;
  logic          r_restart;

  logic [8:0]           w_tgt;
  logic [9:0]           w_bx;
  logic [8:0]           w_by;
  logic                 w_bact;
  logic                 w_bown;
  logic                 w_y_hit;
  logic                 w_capture;
  logic                 w_back_full;
  logic                 w_ovf_set;
  logic                 w_full0, w_full1;
  logic [MAX_SPANS-1:0] w_hit0, w_hit1, w_own0, w_own1;
  logic [MAX_SPANS-1:0] w_front_hit, w_front_own;
  logic                 w_any_hit;
  logic                 w_sel_owner;
  logic                 w_unused_bits;

  assign w_unused_bits = &{1'b0, bulletData[12:4], bulletData[1:0]};

  assign w_tgt  = (lineY == 9'(VIDEO_HEIGHT - 1)) ? 9'd0 : lineY + 9'd1;
  assign w_bx   = bulletData[X_MSB:X_LSB];
  assign w_by   = bulletData[Y_MSB:Y_LSB];
  assign w_bact = bulletData[ACTIVE_BIT];
  assign w_bown = bulletData[OWNER_BIT];

  // 10-bit vertical compare: bullets near y=511 must not wrap onto line 0
  assign w_y_hit = ({1'b0, r_tgt} >= {1'b0, w_by}) &&
                   ({1'b0, r_tgt} <  ({1'b0, w_by} + 10'(BULLET_SIZE)));

  // A lineEnd restart discards whatever word is on the bus this cycle
  assign w_capture   = r_data_valid && !lineEnd && w_bact && w_y_hit;
  assign w_back_full = r_front ? w_full0 : w_full1;
  assign w_ovf_set   = w_capture && w_back_full;

  // Bank 0 is the back bank when r_front=1, bank 1 when r_front=0
  bullet_line_rasterizer_span_bank #(
    .MAX_SPANS   (MAX_SPANS),
    .BULLET_SIZE (BULLET_SIZE)
  ) u_bank0 (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (lineEnd && r_front),
    .i_append    (w_capture && r_front),
    .i_x         (w_bx),
    .i_owner     (w_bown),
    .i_pix_x     (pixX),
    .o_full      (w_full0),
    .o_hit_vec   (w_hit0),
    .o_owner_vec (w_own0)
  );

  bullet_line_rasterizer_span_bank #(
    .MAX_SPANS   (MAX_SPANS),
    .BULLET_SIZE (BULLET_SIZE)
  ) u_bank1 (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (lineEnd && !r_front),
    .i_append    (w_capture && !r_front),
    .i_x         (w_bx),
    .i_owner     (w_bown),
    .i_pix_x     (pixX),
    .o_full      (w_full1),
    .o_hit_vec   (w_hit1),
    .o_owner_vec (w_own1)
  );

  assign w_front_hit = r_front ? w_hit1 : w_hit0;
  assign w_front_own = r_front ? w_own1 : w_own0;

  // Lowest-index matching span decides the colour
  always_comb begin
    w_any_hit   = |w_front_hit;
    w_sel_owner = 1'b0;
    for (int i = MAX_SPANS - 1; i >= 0; i--) begin
      if (w_front_hit[i]) w_sel_owner = w_front_own[i];
    end
  end

  // Scan FSM: lineEnd in any state (re)starts the scan for the new target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tgt        <= '0;
      r_addr       <= '0;
      r_rd_en      <= 1'b0;
      r_data_valid <= 1'b0;
      r_front      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= r_rd_en && !lineEnd;
      if (lineEnd) begin
        r_state <= ST_SCAN;
        r_tgt   <= w_tgt;
        r_addr  <= '0;
        r_rd_en <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_SCAN: begin
            if (r_addr == AW'(MAX_BULLETS - 1)) begin
              r_state <= ST_DRAIN;
              r_rd_en <= 1'b0;
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
          ST_DRAIN: begin
            // Last word is captured into the old back bank on this same edge
            r_front <= ~r_front;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky status: a same-cycle set beats statusClear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (statusClear) r_ovf <= 1'b0;
      if (lineEnd && r_state != ST_IDLE) r_restart <= 1'b1;
      else if (statusClear)              r_restart <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit   <= 1'b0;
      r_color <= '0;
    end else begin
      r_hit   <= active && w_any_hit;
      r_color <= (active && w_any_hit) ? (w_sel_owner ? COLOR_P2 : COLOR_P1) : 12'h000;
    end
  end

  assign bulletRdEn     = r_rd_en;
  assign bulletAddr     = r_addr;
  assign scanBusy       = r_busy;
  assign pixelHit       = r_hit;
  assign pixelColor     = r_color;
  assign overflowSticky = r_ovf;
  assign restartSticky  = r_restart;

endmodule

// File: tb/tb_bullet_line_rasterizer.sv
// tb/tb_bullet_line_rasterizer.sv - self-checking bench for bullet_line_rasterizer
module tb_bullet_line_rasterizer;

  localparam int NB = 64;
  localparam int NS = 8;
  localparam int BS = 12;
  localparam int VH = 480;
  localparam int SCAN_LEN = NB + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        lineEnd;
  logic [8:0]  lineY;
  logic        active;
  logic [9:0]  pixX;
  logic        bulletRdEn;
  logic [5:0]  bulletAddr;
  logic [31:0] bulletData;
  logic        pixelHit;
  logic [11:0] pixelColor;
  logic        scanBusy;
  logic        overflowSticky;
  logic        restartSticky;
  logic        statusClear;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bullet_line_rasterizer dut (
    .clk            (clk),
    .reset          (reset),
    .lineEnd        (lineEnd),
    .lineY          (lineY),
    .active         (active),
    .pixX           (pixX),
    .bulletRdEn     (bulletRdEn),
    .bulletAddr     (bulletAddr),
    .bulletData     (bulletData),
    .pixelHit       (pixelHit),
    .pixelColor     (pixelColor),
    .scanBusy       (scanBusy),
    .overflowSticky (overflowSticky),
    .restartSticky  (restartSticky),
    .statusClear    (statusClear)
  );

  // Bullet table: synchronous read, junk on the bus when not reading
  logic [31:0] bmem [NB];
  always @(posedge clk) bulletData <= bulletRdEn ? bmem[bulletAddr] : $urandom;

  // Reference model: spans the next line should show, in table order
  int m_x[$];
  int m_own[$];
  bit m_ovf;

  function automatic logic [31:0] make_entry(input int x, input int y, input int act, input int own);
    logic [31:0] e;
    e = $urandom;
    e[31:22] = x[9:0];
    e[21:13] = y[8:0];
    e[3] = act[0];
    e[2] = own[0];
    return e;
  endfunction

  function automatic void model_scan(input int ly);
    int t, x, y;
    t = (ly == VH - 1) ? 0 : ly + 1;
    m_x.delete();
    m_own.delete();
    m_ovf = 0;
    for (int a = 0; a < NB; a++) begin
      x = int'(bmem[a][31:22]);
      y = int'(bmem[a][21:13]);
      if (bmem[a][3] && t >= y && t < y + BS) begin
        if (m_x.size() < NS) begin
          m_x.push_back(x);
          m_own.push_back(int'(bmem[a][2]));
        end else begin
          m_ovf = 1;
        end
      end
    end
  endfunction

  function automatic logic [12:0] model_pixel(input int x);
    for (int i = 0; i < m_x.size(); i++) begin
      if (x >= m_x[i] && x < m_x[i] + BS) return {1'b1, (m_own[i] != 0) ? 12'h00F : 12'hF00};
    end
    return 13'h0;
  endfunction

  task automatic clear_table();
    for (int a = 0; a < NB; a++) bmem[a] = make_entry($urandom_range(0, 639), $urandom_range(0, 479), 0, $urandom_range(0, 1));
  endtask

  task automatic drive_pixel(input int x);
    @(negedge clk);
    pixX = x[9:0];
    active = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    statusClear = 1'b1;
    @(negedge clk);
    statusClear = 1'b0;
  endtask

  // Counts busy cycles starting at the negedge just after the lineEnd edge
  task automatic wait_scan(input string name);
    int cnt;
    cnt = 0;
    while (scanBusy && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != SCAN_LEN) begin
      n_fail++;
      $display("FAIL %s scan_len: got %0d busy cycles, expected %0d", name, cnt, SCAN_LEN);
    end
  endtask

  task automatic start_scan(input int ly);
    @(negedge clk);
    lineEnd = 1'b1;
    lineY = ly[8:0];
    @(negedge clk);
    lineEnd = 1'b0;
  endtask

  task automatic run_scan(input int ly, input string name);
    model_scan(ly);
    start_scan(ly);
    wait_scan(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; lineEnd = 1'b0; lineY = '0; active = 1'b0; pixX = '0; statusClear = 1'b0;
    clear_table();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pixelHit, pixelColor, scanBusy, bulletRdEn, bulletAddr, overflowSticky, restartSticky} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: hit=%b color=%h busy=%b rd=%b addr=%0d ovf=%b rst=%b, expected all 0",
               pixelHit, pixelColor, scanBusy, bulletRdEn, bulletAddr, overflowSticky, restartSticky);
    end
    for (int x = 0; x < 640; x += 37) begin
      drive_pixel(x);
      n_checks++;
      if (pixelHit !== 1'b0 || pixelColor !== 12'h0) begin
        n_fail++;
        $display("FAIL reset_no_hit x=%0d: hit=%b color=%h, expected 0/000", x, pixelHit, pixelColor);
      end
    end
  endtask

  task automatic test_single();
    logic [12:0] exp;
    clear_table();
    bmem[5] = make_entry(100, 50, 1, 0);
    run_scan(49, "single");
    for (int x = 95; x <= 116; x++) begin
      drive_pixel(x);
      exp = (x >= 100 && x <= 111) ? {1'b1, 12'hF00} : 13'h0;
      n_checks++;
      if ({pixelHit, pixelColor} !== exp || model_pixel(x) !== exp) begin
        n_fail++;
        $display("FAIL single x=%0d: hit=%b color=%h, expected %b/%h", x, pixelHit, pixelColor, exp[12], exp[11:0]);
      end
    end
    // Vertical bounds: {lineY, expected hit at x=105}
    for (int k = 0; k < 3; k++) begin
      int ly;
      logic eh;
      ly = (k == 0) ? 48 : (k == 1) ? 60 : 61;
      eh = (k == 1);
      run_scan(ly, "vertical");
      drive_pixel(105);
      n_checks++;
      if (pixelHit !== eh || pixelColor !== (eh ? 12'hF00 : 12'h0)) begin
        n_fail++;
        $display("FAIL vertical lineY=%0d: hit=%b color=%h, expected hit=%b", ly, pixelHit, pixelColor, eh);
      end
    end
  endtask

  task automatic test_overflow();
    clear_table();
    for (int k = 0; k < 10; k++) bmem[3 * k + 1] = make_entry(40 + 50 * k, 200, 1, k % 2);
    pulse_clear();
    n_checks++;
    if (overflowSticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pre: got %b, expected 0", overflowSticky);
    end
    run_scan(199, "overflow");
    n_checks++;
    if (overflowSticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b, expected 1", overflowSticky);
    end
    for (int k = 0; k < 10; k++) begin
      logic [12:0] exp;
      drive_pixel(40 + 50 * k + 3);
      exp = (k < 8) ? {1'b1, (k % 2 != 0) ? 12'h00F : 12'hF00} : 13'h0;
      n_checks++;
      if ({pixelHit, pixelColor} !== exp) begin
        n_fail++;
        $display("FAIL ovf_span k=%0d: hit=%b color=%h, expected %b/%h", k, pixelHit, pixelColor, exp[12], exp[11:0]);
      end
    end
    pulse_clear();
    n_checks++;
    if (overflowSticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, expected 0", overflowSticky);
    end
  endtask

  task automatic test_wrap_edge();
    clear_table();
    bmem[63] = make_entry(634, 0, 1, 1);
    run_scan(479, "wrap");
    for (int x = 0; x < 640; x++) begin
      logic eh;
      if (x > 5 && x < 630) continue;
      drive_pixel(x);
      eh = (x >= 634);
      n_checks++;
      if (pixelHit !== eh || pixelColor !== (eh ? 12'h00F : 12'h0)) begin
        n_fail++;
        $display("FAIL wrap_edge x=%0d: hit=%b color=%h, expected hit=%b", x, pixelHit, pixelColor, eh);
      end
    end
  endtask

  task automatic test_restart();
    clear_table();
    bmem[9]  = make_entry(100, 50, 1, 0);
    bmem[40] = make_entry(300, 120, 1, 1);
    pulse_clear();
    start_scan(49);
    repeat (19) @(negedge clk);
    model_scan(120);
    start_scan(120);
    n_checks++;
    if (restartSticky !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_flag: got %b, expected 1", restartSticky);
    end
    wait_scan("restart");
    drive_pixel(105);
    n_checks++;
    if (pixelHit !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_old_target: hit=%b, expected 0", pixelHit);
    end
    drive_pixel(305);
    n_checks++;
    if (pixelHit !== 1'b1 || pixelColor !== 12'h00F) begin
      n_fail++;
      $display("FAIL restart_new_target: hit=%b color=%h, expected 1/00F", pixelHit, pixelColor);
    end
    pulse_clear();
    n_checks++;
    if (restartSticky !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got %b, expected 0", restartSticky);
    end
  endtask

  task automatic test_reset_mid_scan();
    clear_table();
    bmem[2] = make_entry(100, 50, 1, 0);
    run_scan(49, "pre_reset");
    drive_pixel(105);
    n_checks++;
    if (pixelHit !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_hit: hit=%b, expected 1", pixelHit);
    end
    // Leave a restart flag pending so reset has something to clear
    start_scan(49);
    repeat (4) @(negedge clk);
    start_scan(49);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    pixX = 10'd105;
    active = 1'b1;
    @(negedge clk);
    n_checks++;
    if (scanBusy !== 1'b0 || pixelHit !== 1'b0 || bulletRdEn !== 1'b0 || restartSticky !== 1'b0 || pixelColor !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_mid_scan: busy=%b hit=%b rd=%b rst=%b color=%h, expected all 0",
               scanBusy, pixelHit, bulletRdEn, restartSticky, pixelColor);
    end
    reset = 1'b0;
    drive_pixel(105);
    n_checks++;
    if (pixelHit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_counts: hit=%b, expected 0", pixelHit);
    end
  endtask

  task automatic test_filter_owner();
    int xs [4] = '{305, 405, 507, 515};
    logic [11:0] ec [4] = '{12'h000, 12'h00F, 12'hF00, 12'h00F};
    clear_table();
    bmem[3]  = make_entry(300, 100, 0, 0);
    bmem[7]  = make_entry(400, 100, 1, 1);
    bmem[10] = make_entry(500, 100, 1, 0);
    bmem[11] = make_entry(505, 100, 1, 1);
    run_scan(99, "filter");
    for (int i = 0; i < 4; i++) begin
      drive_pixel(xs[i]);
      n_checks++;
      if (pixelHit !== (ec[i] != 12'h0) || pixelColor !== ec[i]) begin
        n_fail++;
        $display("FAIL filter_owner x=%0d: hit=%b color=%h, expected %h", xs[i], pixelHit, pixelColor, ec[i]);
      end
    end
    @(negedge clk);
    pixX = 10'd405;
    active = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pixelHit !== 1'b0 || pixelColor !== 12'h0) begin
      n_fail++;
      $display("FAIL inactive_video: hit=%b color=%h, expected 0/000", pixelHit, pixelColor);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int ly, n, t;
      ly = $urandom_range(12, 470);
      t = ly + 1;
      n = $urandom_range(3, 14);
      clear_table();
      for (int k = 0; k < n; k++)
        bmem[$urandom_range(0, NB - 1)] = make_entry($urandom_range(0, 639), t - $urandom_range(0, 13),
                                                     ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1));
      pulse_clear();
      run_scan(ly, "random");
      for (int x = 0; x < 640; x++) begin
        logic [12:0] exp;
        drive_pixel(x);
        exp = model_pixel(x);
        n_checks++;
        if ({pixelHit, pixelColor} !== exp) begin
          n_fail++;
          $display("FAIL random it=%0d x=%0d: hit=%b color=%h, expected %b/%h", it, x, pixelHit, pixelColor, exp[12], exp[11:0]);
        end
      end
      n_checks++;
      if (overflowSticky !== m_ovf) begin
        n_fail++;
        $display("FAIL random_ovf it=%0d: got %b, expected %b", it, overflowSticky, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_wrap_edge();
    test_restart();
    test_reset_mid_scan();
    test_filter_owner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_line_rasterizer.md
Name: bullet_line_rasterizer

Overview:
- Parametrised successor to the per-pixel bullet overlap loop in the VGA path.
- During each horizontal blanking interval it scans the bullet table once, one entry per cycle, and collects the bullets that intersect the next scanline into a small span buffer. The span buffer is double-buffered.
- During the active line it compares pixel X against only those spans and outputs a registered hit plus a per-owner colour.
- It replaces a MAX_BULLETS-wide combinational compare with a fixed MAX_SPANS compare and adds overflow detection.

Parameters:
- MAX_BULLETS, 64: bullet table entries; power of two.
- MAX_SPANS, 8: bullets stored per line; extras are dropped.
- BULLET_SIZE, 12: square bullet edge in pixels.
- VIDEO_HEIGHT, 480: visible lines; target-line wrap point.
- COLOR_P1, 12'hF00: colour for owner bit 0.
- COLOR_P2, 12'h00F: colour for owner bit 1.

Ports:
- clk  in  1  pixel clock (25 MHz domain of VGATimingGenerator).
- reset  in  1  synchronous, active-high.
- lineEnd  in  1  one-cycle pulse on the first cycle after the last active pixel of a line.
- lineY  in  9  y of the line just ended; sampled with lineEnd.
- active  in  1  high while drawing pixels.
- pixX  in  10  current x.
- bulletRdEn  out  1  bullet table read strobe.
- bulletAddr  out  $clog2(MAX_BULLETS)  bullet index.
- bulletData  in  32  entry fields, valid exactly 1 cycle after a bulletRdEn cycle:
  - [31:22] x
  - [21:13] y
  - [3] active
  - [2] owner
- pixelHit  out  1  registered: pixel lies in a bullet.
- pixelColor  out  12  registered colour; 0 when pixelHit=0.
- scanBusy  out  1  high in state SCAN or DRAIN.
- overflowSticky  out  1  more than MAX_SPANS bullets hit some line.
- restartSticky  out  1  lineEnd arrived while scanning.
- statusClear  in  1  clears both sticky flags.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE; both banks' span counts=0; front bank index=0.
  - All outputs are 0.
- Target line: tgt = (lineY == VIDEO_HEIGHT-1) ? 0 : lineY+1. Computed at lineEnd and held for the whole scan.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE to SCAN on lineEnd:
    - latch tgt;
    - back-bank count=0;
    - bulletAddr=0, bulletRdEn=1.
  - SCAN: each cycle increments bulletAddr while holding bulletRdEn=1. After issuing address MAX_BULLETS-1, go to DRAIN with bulletRdEn=0.
  - DRAIN: lasts exactly one cycle, to consume the last read's data. Then swap banks (front↔back) and go to IDLE.
  - Scan length: MAX_BULLETS+1 cycles from lineEnd to swap (65 with defaults). This fits within the 160-cycle 640x480 blanking interval.
- Capture: a data word is captured when it is valid and entry active=1 and tgt >= y and tgt < y+BULLET_SIZE.
  - The vertical compare uses 10-bit arithmetic (no wrap).
  - A captured word appends {x, owner} to the back bank at index count; count increments.
  - If count == MAX_SPANS, the entry is dropped and overflowSticky is set.
- lineEnd during SCAN or DRAIN:
  - set restartSticky;
  - restart the scan for the new tgt, clearing the back count;
  - no swap occurs for the aborted scan.
- statusClear has lower priority than a same-cycle set: the flag stays 1.
- Pixel path (1-cycle latency): on each clk, pixelHit <= active && (some front-bank span i < count with pixX >= sx_i and pixX < sx_i+BULLET_SIZE).
  - Horizontal compare is 11-bit, so x near 639 does not wrap to the left edge.
  - pixelColor is the colour of the lowest-index matching span, per its owner bit; otherwise 0.
- The swap occurs in DRAIN, which always falls within blanking under the parameters above. The front bank is never written.
- The vertical blank needs no special case: lineEnd for line VIDEO_HEIGHT-1 prepares line 0.

Decomposition:
- Shared package holds:
  - bullet field offsets (X_MSB=31, X_LSB=22, Y_MSB=21, Y_LSB=13, ACTIVE_BIT=3, OWNER_BIT=2);
  - BULLET_SIZE;
  - VIDEO_WIDTH and VIDEO_HEIGHT;
  - the FSM state encoding.
- One sub-module: span_bank. It is a MAX_SPANS-entry register file with count, append, clear and parallel compare-out, instantiated twice.

Test Plan:
- Single bullet {x=100, y=50, active=1, owner=0}; lineEnd with lineY=49:
  - on line 50, pixelHit=1 for pixX 100..111, seen one cycle late;
  - pixelColor=F00;
  - pixX 99 and 112 give hit 0.
- Vertical bounds, same bullet:
  - lineY=48 gives no hit on line 49;
  - lineY=60 gives a hit on line 61;
  - lineY=61 gives no hit on line 62.
- Overflow: 10 active bullets all at y=200; scan for tgt=200:
  - exactly the first 8 (lowest addresses) are drawn;
  - overflowSticky=1;
  - statusClear then returns it to 0.
- Wrap and edge:
  - lineY=479 gives tgt=0, and a bullet at y=0 hits line 0;
  - a bullet at x=634 hits pixX 634..639 only, with no hit at pixX 0..5.
- Restart and reset:
  - lineEnd pulsed 20 cycles into a scan sets restartSticky=1, and the scan completes 65 cycles after the second pulse;
  - reset asserted mid-scan gives scanBusy=0, pixelHit=0 and counts=0 on the next cycle.
- Filtering and owner:
  - an entry with active=0 at a hitting position is never drawn;
  - an owner=1 bullet outputs 00F;
  - for overlapping owner=0 (lower index) and owner=1 bullets, F00 is output.
